fetch_decode_seq: RTL

//  Parametrised instruction fetch + decode sequencer for the single-cycle MIPS lab core. Owns the PC,

---
 rtl/fetch_decode_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_seq.sv
// Fetch/decode sequencer for the MIPS lab core: owns PC, drives ROM,
// latches IR and registers main/ALU control.
module fetch_decode_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 8,
  parameter int          MEM_LAT   = 1,
  parameter int          TICK_DIV  = 25_000_000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               step,
  input  logic               br_taken,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        ir,
  output logic               memtoreg,
  output logic               memwrite,
  output logic               alusrc,
  output logic               regdst,
  output logic               regwrite,
  output logic               branch,
  output logic               jump,
  output logic [2:0]         aluctrl,
  output logic               ir_valid,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [1:0] {
    FETCH, WAITMEM, DECODE, HOLDST
  } state_e;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [1:0]    LAT_LAST  = 2'(MEM_LAT - 1);

  state_e        state_q;
  logic [31:0]   pc_q, ir_q;
  logic [6:0]    ctl_q;
  logic [2:0]    alu_q;
  logic          en_q, irv_q, halt_q, ill_q;
  logic          step_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    lat_q;

  logic [5:0]  op, fn;
  logic [6:0]  ctl_d;
  logic [2:0]  alu_d;
  logic        ill_d, is_halt;
  logic [31:0] pc4, npc_d;
  logic        tick, step_edge, adv;

  // ctl bit order: memtoreg,memwrite,alusrc,regdst,regwrite,branch,jump
  always_comb begin
    op      = imem_rdata[31:26];
    fn      = imem_rdata[5:0];
    ctl_d   = '0;
    alu_d   = '0;
    ill_d   = 1'b0;
    is_halt = (imem_rdata == HALT_WORD);
    if (!is_halt) begin
      case (op)
        6'b000000: begin
          ctl_d = 7'b0001100;
          case (fn)
            6'b100000: alu_d = 3'b010;
            6'b100010: alu_d = 3'b110;
            6'b100100: alu_d = 3'b000;
            6'b100101: alu_d = 3'b001;
            6'b101010: alu_d = 3'b111;
            default: begin
              ctl_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
        6'b100011: begin
          ctl_d = 7'b1010100;
          alu_d = 3'b010;
        end
        6'b101011: begin
          ctl_d = 7'b0110000;
          alu_d = 3'b010;
        end
        6'b000100: begin
          ctl_d = 7'b0000010;
          alu_d = 3'b110;
        end
        6'b001000: begin
          ctl_d = 7'b0010100;
          alu_d = 3'b010;
        end
        6'b000010: begin
          ctl_d = 7'b0000001;
          alu_d = 3'b010;
        end
        default: ill_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    pc4 = pc_q + 32'd4;
    if (ctl_q[0])
      npc_d = {pc4[31:28], ir_q[25:0], 2'b00};
    else if (ctl_q[1] && br_taken)
      npc_d = pc4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    else
      npc_d = pc4;
  end

  assign tick      = mode[1] && (tick_q == TICK_LAST);
  assign step_edge = step & ~step_q;
  assign adv       = mode[1] ? tick : (mode == 2'b01) && step_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ctl_q   <= '0;
      alu_q   <= '0;
      en_q    <= 1'b0;
      irv_q   <= 1'b0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
      step_q  <= 1'b0;
      tick_q  <= '0;
      lat_q   <= '0;
    end else begin
      step_q <= step;
      en_q   <= 1'b0;
      irv_q  <= 1'b0;
      if (!mode[1] || tick)
        tick_q <= '0;
      else
        tick_q <= tick_q + TW'(1);
      case (state_q)
        FETCH: begin
          en_q    <= 1'b1;
          lat_q   <= '0;
          state_q <= WAITMEM;
        end
        WAITMEM: begin
          if (lat_q == LAT_LAST)
            state_q <= DECODE;
          else
            lat_q <= lat_q + 2'd1;
        end
        DECODE: begin
          ir_q    <= imem_rdata;
          ctl_q   <= ctl_d;
          alu_q   <= alu_d;
          ill_q   <= ill_d;
          irv_q   <= 1'b1;
          state_q <= HOLDST;
          if (is_halt)
            halt_q <= 1'b1;
        end
        HOLDST: begin
          // halted core waits here for reset
          if (adv && !halt_q) begin
            pc_q    <= npc_d;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_en   = en_q;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign memtoreg  = ctl_q[6];
  assign memwrite  = ctl_q[5];
  assign alusrc    = ctl_q[4];
  assign regdst    = ctl_q[3];
  assign regwrite  = ctl_q[2];
  assign branch    = ctl_q[1];
  assign jump      = ctl_q[0];
  assign aluctrl   = alu_q;
  assign ir_valid  = irv_q;
  assign halted    = halt_q;
  assign illegal   = ill_q;

endmodule
